// File: rtl/core_irq_ctrl_pkg.sv
// Shared types and default constants for the core interrupt controller.
package core_irq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

  localparam int unsigned DEF_VEC_BASE   = 32'h0000_0010;
  localparam int unsigned DEF_VEC_STRIDE = 32'd4;

endpackage

// File: rtl/core_irq_ctrl_sync2.sv
// irq_sync2: per-channel two-flop synchronizer for the raw interrupt lines.
module irq_sync2
  import core_irq_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Two register stages to resolve metastability on the asynchronous inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_r <= '0;
      sync_r <= '0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/core_irq_ctrl.sv
// Interrupt controller: synchronizes lines, tracks pending bits, arbitrates by
// lowest index and handshakes with the PS. Optional nesting: CORE_IRQ_NESTING_EN.
module core_irq_ctrl
  import core_irq_ctrl_pkg::*;
#(
  parameter int                 NUM_IRQ       = 4,
  parameter int                 PMA_SIZE      = 16,
  parameter int unsigned        VEC_BASE      = DEF_VEC_BASE,
  parameter int unsigned        VEC_STRIDE    = DEF_VEC_STRIDE,
  parameter logic [NUM_IRQ-1:0] IRQ_EDGE_MASK = '0,
  localparam int                ID_W          = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_IRQ-1:0]  irq_in,
  input  logic                ps_irq_mask_wen,
  input  logic [NUM_IRQ-1:0]  ps_irq_mask_dt,
  input  logic                ps_irq_ack,
  input  logic                ps_irq_rti,
  output logic                irq_ps_req,
  output logic [PMA_SIZE-1:0] irq_ps_vec,
  output logic [ID_W-1:0]     irq_ps_id,
  output logic [NUM_IRQ-1:0]  irq_ps_pend,
  output logic [NUM_IRQ-1:0]  irq_ps_mask
);

  function automatic logic [PMA_SIZE-1:0] vec_of(input logic [ID_W-1:0] idx);
    logic [31:0] full;
    full = VEC_BASE + (32'(idx) * VEC_STRIDE);
    return full[PMA_SIZE-1:0];
  endfunction

  logic [NUM_IRQ-1:0]  sync_s;
  logic [NUM_IRQ-1:0]  prev_r;
  logic [NUM_IRQ-1:0]  pend_r;
  logic [NUM_IRQ-1:0]  pend_nxt_s;
  logic [NUM_IRQ-1:0]  mask_r;
  logic [NUM_IRQ-1:0]  cand_s;
  logic [NUM_IRQ-1:0]  set_s;
  logic [NUM_IRQ-1:0]  clr_s;
  irq_state_e          state_r;
  irq_state_e          state_nxt_s;
  logic                req_r;
  logic                req_nxt_s;
  logic [ID_W-1:0]     id_r;
  logic [ID_W-1:0]     id_nxt_s;
  logic [PMA_SIZE-1:0] vec_r;
  logic [PMA_SIZE-1:0] vec_nxt_s;
  logic [ID_W-1:0]     win_id_s;
  logic                win_vld_s;

`ifdef CORE_IRQ_NESTING_EN
  logic [ID_W-1:0]     stack_r [NUM_IRQ];
  logic [NUM_IRQ-1:0]  stk_vld_r;
  logic                push_s;
  logic                pop_s;
`endif

  irq_sync2 #(
    .WIDTH (NUM_IRQ)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (irq_in),
    .q     (sync_s)
  );

  // Pending bits: level channels follow the synchronized line, edge channels
  // latch a rising edge; a simultaneous set beats the ack-driven clear.
  always_comb begin
    set_s      = sync_s & ~prev_r;
    pend_nxt_s = (IRQ_EDGE_MASK & (set_s | (pend_r & ~clr_s))) | (~IRQ_EDGE_MASK & sync_s);
    cand_s     = pend_r & mask_r;
  end

  // Fixed-priority encoder, lowest index wins.
  always_comb begin
    win_vld_s = 1'b0;
    win_id_s  = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (cand_s[i] && !win_vld_s) begin
        win_vld_s = 1'b1;
        win_id_s  = ID_W'(i);
      end else begin
        win_id_s  = win_id_s;
      end
    end
  end

  // Handshake FSM next-state and next-output logic.
  always_comb begin
    state_nxt_s = state_r;
    req_nxt_s   = req_r;
    id_nxt_s    = id_r;
    vec_nxt_s   = vec_r;
    clr_s       = '0;
`ifdef CORE_IRQ_NESTING_EN
    push_s      = 1'b0;
    pop_s       = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (win_vld_s) begin
          state_nxt_s = ST_REQ;
          req_nxt_s   = 1'b1;
          id_nxt_s    = win_id_s;
          vec_nxt_s   = vec_of(win_id_s);
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (ps_irq_ack) begin
          state_nxt_s = ST_SERVICE;
          req_nxt_s   = 1'b0;
          clr_s       = NUM_IRQ'(1'b1) << id_r;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_SERVICE: begin
`ifdef CORE_IRQ_NESTING_EN
        // rti is served before a new nested request in the same cycle.
        if (ps_irq_rti) begin
          if (stk_vld_r[0]) begin
            pop_s       = 1'b1;
            state_nxt_s = ST_SERVICE;
            id_nxt_s    = stack_r[0];
            vec_nxt_s   = vec_of(stack_r[0]);
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else if (win_vld_s && (win_id_s < id_r)) begin
          push_s      = 1'b1;
          state_nxt_s = ST_REQ;
          req_nxt_s   = 1'b1;
          id_nxt_s    = win_id_s;
          vec_nxt_s   = vec_of(win_id_s);
        end else begin
          state_nxt_s = ST_SERVICE;
        end
`else
        if (ps_irq_rti) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SERVICE;
        end
`endif
      end
      default: begin
        state_nxt_s = ST_IDLE;
        req_nxt_s   = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered outputs, pending/mask registers and edge-detect history.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_r  <= 1'b0;
      id_r   <= '0;
      vec_r  <= vec_of('0);
      pend_r <= '0;
      mask_r <= '0;
      prev_r <= '0;
    end else begin
      req_r  <= req_nxt_s;
      id_r   <= id_nxt_s;
      vec_r  <= vec_nxt_s;
      pend_r <= pend_nxt_s;
      prev_r <= sync_s;
      if (ps_irq_mask_wen) begin
        mask_r <= ps_irq_mask_dt;
      end
    end
  end

`ifdef CORE_IRQ_NESTING_EN
  // Interrupted-id stack kept as a shift register; entry 0 is the top.
  always_ff @(posedge clk) begin
    if (reset) begin
      stk_vld_r <= '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
        stack_r[i] <= '0;
      end
    end else if (push_s) begin
      stk_vld_r  <= (stk_vld_r << 1) | NUM_IRQ'(1'b1);
      stack_r[0] <= id_r;
      for (int i = 1; i < NUM_IRQ; i++) begin
        stack_r[i] <= stack_r[i-1];
      end
    end else if (pop_s) begin
      stk_vld_r <= stk_vld_r >> 1;
      for (int i = 0; i < NUM_IRQ - 1; i++) begin
        stack_r[i] <= stack_r[i+1];
      end
    end
  end
`endif

  assign irq_ps_req  = req_r;
  assign irq_ps_vec  = vec_r;
  assign irq_ps_id   = id_r;
  assign irq_ps_pend = pend_r;
  assign irq_ps_mask = mask_r;

endmodule
